// File: rtl/fila_pkg.sv
// Shared types and defaults for the fila command front-end (FILA_CMD_AUTOREPEAT_EN adds REPEAT_CYCLES).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fila_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int DEPTH_DEF      = 8;
    localparam int DEB_CYCLES_DEF = 20;

`ifdef FILA_CMD_AUTOREPEAT_EN
    localparam int REPEAT_CYCLES = 5000;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } cmd_state_t;

    // Unsigned occupancy test; anything at or above capacity counts as full.
    function automatic logic len_full(input int unsigned len, input int unsigned depth);
        return (len >= depth);
    endfunction

endpackage

// File: rtl/fila_cmd_btn_debounce.sv
// Button conditioner: 2-flop sync, stable-count debounce, one-cycle rise pulse (FILA_CMD_AUTOREPEAT_EN adds hold-repeat).
// Latency: rise_o fires DEB_CYCLES+2 cycles after the raw input settles high.
// Backpressure: none; the pulse is fire-and-forget.
module btn_debounce
    import fila_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rise_o
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

`ifdef FILA_CMD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_fire;

    assign rep_fire = level_q && (rep_cnt_q == REP_MAX);

    always_comb begin
        rep_cnt_d = '0;
        if (level_q && !rep_fire) begin
            rep_cnt_d = rep_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`endif

    // The counter only runs while the synchronised sample disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`ifdef FILA_CMD_AUTOREPEAT_EN
        rise_d = rise_d | rep_fire;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/fila_cmd.sv
// Turns raw enqueue/dequeue buttons into guarded one-cycle fila strobes (FILA_CMD_AUTOREPEAT_EN enables hold-repeat).
// Latency: 1 cycle from debounced edge when idle, 2 when queued behind another command.
// Backpressure: full/empty rejects with an err pulse; a repeat request while one is pending is dropped.
module fila_cmd
    import fila_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic              clk_10KHz,
    input  logic              reset,
    input  logic              btn_enq,
    input  logic              btn_deq,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [DATA_W-1:0] len_in,
    output logic [DATA_W-1:0] data_out,
    output logic              enqueue_out,
    output logic              dequeue_out,
    output logic              err_full,
    output logic              err_empty,
    output logic              busy
);

    cmd_state_t        state_q, state_d;
    logic              pend_enq_q, pend_enq_d;
    logic              pend_deq_q, pend_deq_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              enq_req, deq_req;
    logic              enq_clr;
    logic              any_work;
    logic              q_empty, q_full;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enq (
        .clk_i  (clk_10KHz),
        .rst_ni (reset),
        .btn_i  (btn_enq),
        .rise_o (enq_req)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_deq (
        .clk_i  (clk_10KHz),
        .rst_ni (reset),
        .btn_i  (btn_deq),
        .rise_o (deq_req)
    );

    assign q_empty  = (len_in == '0);
    assign q_full   = len_full(32'(len_in), DEPTH);
    assign any_work = pend_enq_q | pend_deq_q | enq_req | deq_req;

    // ISSUE acts on latched flags only, so a request arriving in ISSUE waits for the next slot.
    always_comb begin
        state_d     = state_q;
        pend_enq_d  = pend_enq_q | enq_req;
        pend_deq_d  = pend_deq_q | deq_req;
        enq_clr     = 1'b0;
        enqueue_out = 1'b0;
        dequeue_out = 1'b0;
        err_full    = 1'b0;
        err_empty   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_work) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = SETTLE;
                if (pend_deq_q) begin
                    if (q_empty) err_empty   = 1'b1;
                    else         dequeue_out = 1'b1;
                    pend_deq_d = deq_req;
                end else if (pend_enq_q) begin
                    if (q_full) err_full    = 1'b1;
                    else        enqueue_out = 1'b1;
                    pend_enq_d = enq_req;
                    enq_clr    = 1'b1;
                end
            end
            SETTLE: begin
                state_d = any_work ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d = data_q;
        if (enq_req && (!pend_enq_q || enq_clr)) begin
            data_d = sw_data;
        end
    end

    always_ff @(posedge clk_10KHz or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pend_enq_q <= 1'b0;
            pend_deq_q <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            pend_enq_q <= pend_enq_d;
            pend_deq_q <= pend_deq_d;
            data_q     <= data_d;
        end
    end

    assign data_out = data_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fila_cmd.sv
// Scoreboard bench for fila_cmd: directed button sequences queue expected strobes, a monitor checks them.
module tb_fila_cmd;
    import fila_pkg::*;

    localparam int DW  = 8;
    localparam int DEB = DEB_CYCLES_DEF;

    localparam int K_ENQ = 1;
    localparam int K_DEQ = 2;
    localparam int K_EFL = 3;
    localparam int K_EEM = 4;

    logic          clk;
    logic          reset;
    logic          btn_enq, btn_deq;
    logic [DW-1:0] sw_data, len_in;
    logic [DW-1:0] data_out;
    logic          enqueue_out, dequeue_out, err_full, err_empty, busy;

    typedef struct {
        int            kind;
        logic [DW-1:0] dat;
        int            min_c;
        int            max_c;
        int            gap;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   last_ev    = -100;

    fila_cmd dut (
        .clk_10KHz   (clk),
        .reset       (reset),
        .btn_enq     (btn_enq),
        .btn_deq     (btn_deq),
        .sw_data     (sw_data),
        .len_in      (len_in),
        .data_out    (data_out),
        .enqueue_out (enqueue_out),
        .dequeue_out (dequeue_out),
        .err_full    (err_full),
        .err_empty   (err_empty),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, required < 20000", cyc);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [DW-1:0] dat,
                             input int min_c, input int max_c, input int gap);
        exp_t e;
        e.kind  = kind;
        e.dat   = dat;
        e.min_c = min_c;
        e.max_c = max_c;
        e.gap   = gap;
        q.push_back(e);
    endtask

    task automatic press(input logic enq, input logic deq);
        btn_enq = enq;
        btn_deq = deq;
        tick(DEB + 10);
        btn_enq = 1'b0;
        btn_deq = 1'b0;
        tick(DEB + 10);
    endtask

    // Monitor: every strobe or error pulse must match the head of the expected queue.
    always @(negedge clk) begin
        int   n;
        int   k;
        exp_t e;
        if (reset) begin
            n = int'(enqueue_out) + int'(dequeue_out) + int'(err_full) + int'(err_empty);
            if (n > 0) begin
                k = enqueue_out ? K_ENQ : dequeue_out ? K_DEQ : err_full ? K_EFL : K_EEM;
                check("exclusive_pulse", n, 1);
                check("busy_at_pulse", int'(busy), 1);
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, required none", k, cyc);
                end else begin
                    e = q.pop_front();
                    check("pulse_kind", k, e.kind);
                    if (e.kind == K_ENQ) check("data_out", int'(data_out), int'(e.dat));
                    if (e.max_c != 0) begin
                        vectors++;
                        if (cyc < e.min_c || cyc > e.max_c) begin
                            miscompares++;
                            $display("FAIL pulse_latency: got cycle %0d, required %0d..%0d", cyc, e.min_c, e.max_c);
                        end
                    end
                    if (e.gap != 0) check("pulse_gap", cyc - last_ev, e.gap);
                end
                last_ev = cyc;
            end
        end
    end

    initial begin
        int c;
        bit seen;
        reset   = 1'b0;
        btn_enq = 1'b0;
        btn_deq = 1'b0;
        sw_data = '0;
        len_in  = '0;

        // Reset held while buttons chatter.
        for (int i = 0; i < 6; i++) begin
            tick(1);
            btn_enq = ~btn_enq;
            btn_deq = (i % 3) == 0;
        end
        tick(1);
        check("rst_enqueue_out", int'(enqueue_out), 0);
        check("rst_dequeue_out", int'(dequeue_out), 0);
        check("rst_err_full",    int'(err_full), 0);
        check("rst_err_empty",   int'(err_empty), 0);
        check("rst_busy",        int'(busy), 0);
        check("rst_data_out",    int'(data_out), 0);
        btn_enq = 1'b0;
        btn_deq = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(DEB + 5);

        // Bouncing enqueue press, queue empty.
        len_in  = 8'd0;
        sw_data = 8'h11;
        for (int i = 0; i < 6; i++) begin
            btn_enq = ~btn_enq;
            tick(1);
        end
        btn_enq = 1'b1;
        c = cyc;
        expect_ev(K_ENQ, 8'h11, c + DEB + 1, c + DEB + 4, 0);
        tick(DEB + 10);
        sw_data = 8'h22;
        btn_enq = 1'b0;
        tick(DEB + 10);

        // Full rejection then acceptance one below capacity.
        len_in  = 8'd8;
        sw_data = 8'h33;
        expect_ev(K_EFL, 8'h00, 0, 0, 0);
        press(1'b1, 1'b0);
        len_in  = 8'd7;
        sw_data = 8'h44;
        expect_ev(K_ENQ, 8'h44, 0, 0, 0);
        press(1'b1, 1'b0);
        len_in  = 8'd200;
        expect_ev(K_EFL, 8'h00, 0, 0, 0);
        press(1'b1, 1'b0);

        // Empty rejection, then a legal dequeue.
        len_in = 8'd0;
        expect_ev(K_EEM, 8'h00, 0, 0, 0);
        press(1'b0, 1'b1);
        len_in = 8'd5;
        expect_ev(K_DEQ, 8'h00, 0, 0, 0);
        press(1'b0, 1'b1);

        // Simultaneous presses: dequeue first, enqueue two cycles later.
        len_in  = 8'd3;
        sw_data = 8'h55;
        expect_ev(K_DEQ, 8'h00, 0, 0, 0);
        expect_ev(K_ENQ, 8'h55, 0, 0, 2);
        press(1'b1, 1'b1);

        // Reset lands in SETTLE while the enqueue is still pending.
        sw_data = 8'h66;
        expect_ev(K_DEQ, 8'h00, 0, 0, 0);
        btn_enq = 1'b1;
        btn_deq = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < DEB + 20 && !seen; i++) begin
            tick(1);
            seen = dequeue_out;
        end
        check("wait_dequeue_before_reset", int'(seen), 1);
        tick(1);
        check("busy_in_settle", int'(busy), 1);
        reset   = 1'b0;
        btn_enq = 1'b0;
        btn_deq = 1'b0;
        tick(2);
        check("busy_during_reset", int'(busy), 0);
        check("data_during_reset", int'(data_out), 0);
        reset = 1'b1;
        tick(3 * DEB);
        sw_data = 8'h77;
        expect_ev(K_ENQ, 8'h77, 0, 0, 0);
        press(1'b1, 1'b0);

        tick(5);
        check("pending_expected_left", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
